// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator datapath blocks.
//   BCD_DIGITS  number of packed BCD digits handled by a converter
//   BIN_W       width of the binary accumulator / result
//   DIGIT_MAX   largest legal BCD digit value
//   state_t     converter control states
package calc_pkg;

    localparam int         BCD_DIGITS = 4;
    localparam int         BIN_W      = 14;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational decimal multiply-accumulate, res = acc*10 + digit.
//   acc     [W-1:0]  running binary value
//   digit   [3:0]    next BCD digit
//   res     [W-1:0]  acc*10 + digit, truncated to W bits
//   invalid          digit is not a legal BCD digit (>9)
module bcd_mac10
    import calc_pkg::*;
#(
    parameter int W = BIN_W
) (
    input  logic [W-1:0] acc,
    input  logic [3:0]   digit,
    output logic [W-1:0] res,
    output logic         invalid
);

    // x10 as shift-and-add so no multiplier is inferred.
    assign res     = (acc << 3) + (acc << 1) + W'(digit);
    assign invalid = (digit > DIGIT_MAX);

endmodule

// File: rtl/bcd2binary.sv
// bcd2binary: sequential packed-BCD to binary converter, one digit per clock,
// most significant digit first. Fixed latency: done is high in the 5th cycle
// after the start edge.
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   start   request pulse, sampled only in IDLE
//   bcd     packed BCD input, top nibble is the most significant digit
//   binary  registered result (0 when any digit was invalid)
//   busy    conversion in progress or completing
//   done    one-cycle completion strobe
//   err     invalid digit seen in the last conversion
module bcd2binary
    import calc_pkg::*;
#(
    parameter int BCD_DIGITS = calc_pkg::BCD_DIGITS,
    parameter int BIN_W      = calc_pkg::BIN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*BCD_DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]        binary,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int IDX_W = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

    state_t                  state, state_nxt;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [BIN_W-1:0]        acc;
    logic [BIN_W-1:0]        mac_res;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              digit;
    logic                    err_lat;
    logic                    dig_bad;
    logic                    err_nxt;
    logic                    last;

    assign digit   = bcd_q[{idx, 2'b00} +: 4];
    assign last    = (idx == '0);
    assign err_nxt = err_lat | dig_bad;

    bcd_mac10 #(.W(BIN_W)) u_mac (
        .acc     (acc),
        .digit   (digit),
        .res     (mac_res),
        .invalid (dig_bad)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath. The final CONV edge registers the result directly from the
    // MAC output so binary/err are valid in the same cycle done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q   <= '0;
            acc     <= '0;
            idx     <= '0;
            err_lat <= 1'b0;
            binary  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_q   <= bcd;
                        acc     <= '0;
                        err_lat <= 1'b0;
                        idx     <= IDX_W'(BCD_DIGITS - 1);
                    end
                end
                CONV: begin
                    acc     <= mac_res;
                    err_lat <= err_nxt;
                    idx     <= idx - IDX_W'(1);
                    if (last) begin
                        binary <= err_nxt ? '0 : mac_res;
                        err    <= err_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
